mem_arb_ctrl: RTL and testbench

//  Parametrised miss controller/arbiter between split I/D caches and one unified memory.

---
 rtl/mem_arb_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_mem_arb_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb_ctrl.sv
// Miss controller/arbiter between split I/D caches and one unified memory port.
// Optional perf counters (i_miss_cnt, d_miss_cnt, wb_cnt) enabled by defining PERF_CNT_EN.
module mem_arb_ctrl #(
  parameter int WORD_W        = 16,
  parameter int ADDR_W        = 16,
  parameter int WORDS_PER_BLK = 4,
  parameter int INDEX_W       = 6,
  localparam int OFF_W        = $clog2(WORDS_PER_BLK),
  localparam int BLK_W        = WORD_W * WORDS_PER_BLK,
  localparam int TAG_W        = ADDR_W - OFF_W - INDEX_W,
  localparam int BA_W         = ADDR_W - OFF_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_rd,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [WORD_W-1:0] wrt_data,
  input  logic              i_hit,
  input  logic [BLK_W-1:0]  i_blk,
  input  logic              d_hit,
  input  logic              d_dirty,
  input  logic [TAG_W-1:0]  d_vtag,
  input  logic [BLK_W-1:0]  d_blk,
  output logic              i_we,
  output logic [BLK_W-1:0]  i_wblk,
  output logic              d_re,
  output logic              d_we,
  output logic [BA_W-1:0]   d_caddr,
  output logic [BLK_W-1:0]  d_wblk,
  output logic              wdirty,
  output logic              mem_re,
  output logic              mem_we,
  output logic [BA_W-1:0]   mem_addr,
  output logic [BLK_W-1:0]  mem_wdata,
  input  logic [BLK_W-1:0]  mem_rdata,
  input  logic              mem_rdy,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] rd_data,
  output logic              freeze
`ifdef PERF_CNT_EN
  ,
  output logic [15:0]       i_miss_cnt,
  output logic [15:0]       d_miss_cnt,
  output logic [15:0]       wb_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE, WB_REQ, WB_WAIT, DF_REQ, DF_WAIT, IF_REQ, IF_WAIT, DONE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] l_iaddr, l_daddr;
  logic [WORD_W-1:0] l_wdata;
  logic              l_drd, l_dwr, l_imiss, l_dmiss;
  logic [TAG_W-1:0]  l_vtag;
  logic [BLK_W-1:0]  l_ifill;

  function automatic logic [WORD_W-1:0] get_word(input logic [BLK_W-1:0] blk,
                                                 input logic [OFF_W-1:0] off);
    return blk[off*WORD_W +: WORD_W];
  endfunction

  function automatic logic [BLK_W-1:0] put_word(input logic [BLK_W-1:0]  blk,
                                                input logic [OFF_W-1:0]  off,
                                                input logic [WORD_W-1:0] w);
    logic [BLK_W-1:0] r;
    r = blk;
    r[off*WORD_W +: WORD_W] = w;
    return r;
  endfunction

  logic i_miss, d_miss, wb, any_miss;
  assign i_miss   = i_rd & ~i_hit;
  assign d_miss   = (d_rd | d_wr) & ~d_hit;
  assign wb       = d_miss & d_dirty;
  assign any_miss = i_miss | d_miss;

  logic [OFF_W-1:0] i_off, d_off, l_ioff, l_doff;
  logic [BA_W-1:0]  l_iba, l_dba, vic_ba;
  assign i_off  = i_addr[OFF_W-1:0];
  assign d_off  = d_addr[OFF_W-1:0];
  assign l_ioff = l_iaddr[OFF_W-1:0];
  assign l_doff = l_daddr[OFF_W-1:0];
  assign l_iba  = l_iaddr[ADDR_W-1:OFF_W];
  assign l_dba  = l_daddr[ADDR_W-1:OFF_W];
  assign vic_ba = {l_vtag, l_daddr[OFF_W +: INDEX_W]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      l_iaddr <= '0;
      l_daddr <= '0;
      l_wdata <= '0;
      l_drd   <= 1'b0;
      l_dwr   <= 1'b0;
      l_imiss <= 1'b0;
      l_dmiss <= 1'b0;
      l_vtag  <= '0;
      l_ifill <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_miss) begin
        l_iaddr <= i_addr;
        l_daddr <= d_addr;
        l_wdata <= wrt_data;
        l_drd   <= d_rd;
        l_dwr   <= d_wr;
        l_imiss <= i_miss;
        l_dmiss <= d_miss;
        l_vtag  <= d_vtag;
      end
      if (state == IF_WAIT && mem_rdy) l_ifill <= mem_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    i_we      = 1'b0;
    i_wblk    = '0;
    d_re      = 1'b0;
    d_we      = 1'b0;
    d_caddr   = d_addr[ADDR_W-1:OFF_W];
    d_wblk    = '0;
    wdirty    = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    instr     = '0;
    rd_data   = '0;
    freeze    = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (any_miss) begin
            freeze = 1'b1;
            if (wb)          state_nxt = WB_REQ;
            else if (d_miss) state_nxt = DF_REQ;
            else             state_nxt = IF_REQ;
          end else begin
            instr   = get_word(i_blk, i_off);
            rd_data = get_word(d_blk, d_off);
            if (d_wr) begin
              d_we   = 1'b1;
              wdirty = 1'b1;
              d_wblk = put_word(d_blk, d_off, wrt_data);
            end
          end
        end
        WB_REQ: begin
          freeze    = 1'b1;
          d_re      = 1'b1;
          d_caddr   = vic_ba;
          mem_we    = 1'b1;
          mem_addr  = vic_ba;
          mem_wdata = d_blk;
          state_nxt = WB_WAIT;
        end
        WB_WAIT: begin
          freeze  = 1'b1;
          d_caddr = l_dba;
          if (mem_rdy) state_nxt = DF_REQ;
        end
        DF_REQ: begin
          freeze    = 1'b1;
          d_caddr   = l_dba;
          mem_re    = 1'b1;
          mem_addr  = l_dba;
          state_nxt = DF_WAIT;
        end
        DF_WAIT: begin
          freeze  = 1'b1;
          d_caddr = l_dba;
          if (mem_rdy) begin
            d_we      = 1'b1;
            wdirty    = l_dwr;
            d_wblk    = l_dwr ? put_word(mem_rdata, l_doff, l_wdata) : mem_rdata;
            state_nxt = l_imiss ? IF_REQ : DONE;
          end
        end
        IF_REQ: begin
          freeze    = 1'b1;
          d_caddr   = l_dba;
          mem_re    = 1'b1;
          mem_addr  = l_iba;
          state_nxt = IF_WAIT;
        end
        IF_WAIT: begin
          freeze  = 1'b1;
          d_caddr = l_dba;
          if (mem_rdy) begin
            i_we      = 1'b1;
            i_wblk    = mem_rdata;
            state_nxt = DONE;
          end
        end
        DONE: begin
          d_re    = 1'b1;
          d_caddr = l_dba;
          instr   = l_imiss ? get_word(l_ifill, l_ioff) : get_word(i_blk, l_ioff);
          rd_data = l_drd ? get_word(d_blk, l_doff) : '0;
          // A store that hit while only the I-side missed is committed here
          if (l_dwr && !l_dmiss) begin
            d_we   = 1'b1;
            wdirty = 1'b1;
            d_wblk = put_word(d_blk, l_doff, l_wdata);
          end
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_miss_cnt <= '0;
      d_miss_cnt <= '0;
      wb_cnt     <= '0;
    end else if (state == IDLE && any_miss) begin
      if (i_miss && i_miss_cnt != 16'hFFFF) i_miss_cnt <= i_miss_cnt + 16'd1;
      if (d_miss && d_miss_cnt != 16'hFFFF) d_miss_cnt <= d_miss_cnt + 16'd1;
      if (wb && wb_cnt != 16'hFFFF)         wb_cnt     <= wb_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Scoreboard bench for mem_arb_ctrl: the driver pushes expected memory/cache events
// computed from transaction parameters; a monitor pops and compares as the DUT emits them.
module tb_mem_arb_ctrl;
  logic        clk, rst_n;
  logic        i_rd, d_rd, d_wr, i_hit, d_hit, d_dirty;
  logic [15:0] i_addr, d_addr, wrt_data;
  logic [7:0]  d_vtag;
  logic [63:0] i_blk, d_blk, i_wblk, d_wblk, mem_wdata, mem_rdata;
  logic        i_we, d_re, d_we, wdirty, mem_re, mem_we, mem_rdy, freeze;
  logic [13:0] d_caddr, mem_addr;
  logic [15:0] instr, rd_data;
`ifdef PERF_CNT_EN
  logic [15:0] i_miss_cnt, d_miss_cnt, wb_cnt;
`endif

  mem_arb_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_rd(i_rd), .i_addr(i_addr), .d_rd(d_rd), .d_wr(d_wr),
    .d_addr(d_addr), .wrt_data(wrt_data), .i_hit(i_hit), .i_blk(i_blk), .d_hit(d_hit),
    .d_dirty(d_dirty), .d_vtag(d_vtag), .d_blk(d_blk), .i_we(i_we), .i_wblk(i_wblk),
    .d_re(d_re), .d_we(d_we), .d_caddr(d_caddr), .d_wblk(d_wblk), .wdirty(wdirty),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .instr(instr), .rd_data(rd_data),
    .freeze(freeze)
`ifdef PERF_CNT_EN
    , .i_miss_cnt(i_miss_cnt), .d_miss_cnt(d_miss_cnt), .wb_cnt(wb_cnt)
`endif
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          kind;   // 0 mem write, 1 mem read, 2 D write, 3 I write, 4 result
    logic [13:0] addr;
    logic [63:0] data;
    logic        flag;
    logic [15:0] iw, dw;
    logic        ci, cd;
  } ev_t;

  ev_t q[$];
  int  total = 0, bad = 0;
  int  force_lat = 0, lat_total = 0;
  bit  mon_off = 0;
  int  pc_i = 0, pc_d = 0, pc_w = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] wsel(logic [63:0] b, int o);
    return b[o*16 +: 16];
  endfunction

  function automatic logic [63:0] wput(logic [63:0] b, int o, logic [15:0] w);
    logic [63:0] r;
    r = b;
    r[o*16 +: 16] = w;
    return r;
  endfunction

  function automatic logic [63:0] memval(logic [13:0] ba);
    logic [15:0] b;
    b = {2'b00, ba};
    return {b * 16'd3 + 16'h0011, ~b, b ^ 16'h5A5A, b + 16'h1000};
  endfunction

  function automatic ev_t mk(int kind, logic [13:0] a, logic [63:0] d, logic f);
    ev_t e;
    e.kind = kind; e.addr = a; e.data = d; e.flag = f;
    e.iw = '0; e.dw = '0; e.ci = 0; e.cd = 0;
    return e;
  endfunction

  // Memory responder: one rdy pulse per strobe after 1..6 cycles
  initial begin
    logic [13:0] a;
    int lat;
    mem_rdy = 0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n && (mem_re || mem_we)) begin
        a = mem_addr;
        lat = (force_lat != 0) ? force_lat : int'($urandom_range(1, 6));
        lat_total += lat;
        repeat (lat) @(posedge clk);
        #1 mem_rdy = 1;
        mem_rdata = memval(a);
        @(posedge clk);
        #1 mem_rdy = 0;
      end
    end
  end

  task automatic mon_ev(int kind, logic [13:0] a, logic [63:0] d, logic f);
    ev_t e;
    if (q.size() == 0) begin
      total++; bad++;
      $display("FAIL unexpected_event kind=%0d actual_addr=%h expected=none @%0t", kind, a, $time);
      return;
    end
    e = q.pop_front();
    chk("event_kind", kind, e.kind);
    if (kind != e.kind) return;
    case (kind)
      0: begin chk("memw_addr", a, e.addr); chk("memw_data", d, e.data); end
      1: chk("memr_addr", a, e.addr);
      2: begin
        chk("dwr_addr", a, e.addr); chk("dwr_data", d, e.data); chk("dwr_dirty", f, e.flag);
      end
      3: chk("iwr_data", d, e.data);
      default: begin
        if (e.ci) chk("instr", d[31:16], e.iw);
        if (e.cd) chk("rd_data", d[15:0], e.dw);
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (rst_n && !mon_off) begin
      if (mem_we) mon_ev(0, mem_addr, mem_wdata, 1'b0);
      if (mem_re) mon_ev(1, mem_addr, 64'h0, 1'b0);
      if (d_we)   mon_ev(2, d_caddr, d_wblk, wdirty);
      if (i_we)   mon_ev(3, 14'h0, i_wblk, 1'b0);
      if (!freeze && (i_rd || d_rd || d_wr)) mon_ev(4, 14'h0, {32'h0, instr, rd_data}, 1'b0);
    end
  end

  // Call at posedge+1 with the DUT in IDLE; returns the number of frozen cycles.
  task automatic run_txn(input logic ir, ih, input logic [15:0] ia,
                         input logic dr, dw, dh, dd, input logic [15:0] da,
                         input logic [7:0] vt, input logic [15:0] wd,
                         input logic [63:0] ib, db, output int fcnt);
    int ioff, doff, nops, lat0, exp_f;
    logic [13:0] iba, dba;
    logic imiss, dmiss, wbk;
    logic [63:0] wblk, dafter;
    ev_t r;
    bit done;
    i_rd = ir; i_hit = ih; i_addr = ia; d_rd = dr; d_wr = dw; d_hit = dh;
    d_dirty = dd; d_addr = da; d_vtag = vt; wrt_data = wd; i_blk = ib; d_blk = db;
    ioff = int'(ia % 16'd4); doff = int'(da % 16'd4);
    iba = 14'(ia >> 2); dba = 14'(da >> 2);
    imiss = ir && !ih; dmiss = (dr || dw) && !dh; wbk = dmiss && dd;
    nops = int'(imiss) + int'(dmiss) + int'(wbk);
    dafter = db;
    if (!imiss && !dmiss) begin
      if (dw) begin
        dafter = wput(db, doff, wd);
        q.push_back(mk(2, dba, dafter, 1'b1));
      end
    end else begin
      if (imiss) pc_i = (pc_i == 65535) ? pc_i : pc_i + 1;
      if (dmiss) pc_d = (pc_d == 65535) ? pc_d : pc_d + 1;
      if (wbk)   pc_w = (pc_w == 65535) ? pc_w : pc_w + 1;
      if (wbk) q.push_back(mk(0, 14'((int'(vt) << 6) | (int'(dba) % 64)), db, 1'b0));
      if (dmiss) begin
        q.push_back(mk(1, dba, 64'h0, 1'b0));
        wblk = dw ? wput(memval(dba), doff, wd) : memval(dba);
        dafter = wblk;
        q.push_back(mk(2, dba, wblk, dw));
      end
      if (imiss) begin
        q.push_back(mk(1, iba, 64'h0, 1'b0));
        q.push_back(mk(3, 14'h0, memval(iba), 1'b0));
      end
      if (dw && !dmiss) q.push_back(mk(2, dba, wput(db, doff, wd), 1'b1));
    end
    if (ir || dr || dw) begin
      r = mk(4, 14'h0, 64'h0, 1'b0);
      r.ci = ir; r.cd = dr;
      r.iw = imiss ? wsel(memval(iba), ioff) : wsel(ib, ioff);
      r.dw = wsel(dafter, doff);
      q.push_back(r);
    end
    lat0 = lat_total;
    fcnt = 0;
    done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (freeze) begin
        fcnt++;
        if (d_we) d_blk = d_wblk;   // emulate the D-cache line being refilled
      end else done = 1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL txn_timeout actual=frozen expected=unfrozen_within_300 @%0t", $time);
    end
    @(posedge clk);
    #1;
    i_rd = 0; d_rd = 0; d_wr = 0;
    exp_f = (nops == 0) ? 0 : 1 + nops + (lat_total - lat0);
    chk("freeze_cycles", fcnt, exp_f);
    chk("queue_drained", q.size(), 0);
    q.delete();
  endtask

  initial begin
    int f;
    logic [15:0] a16;
    i_rd = 1; i_hit = 1; d_rd = 1; d_wr = 0; d_hit = 1; d_dirty = 1;
    i_addr = 16'h0005; d_addr = 16'h1234; wrt_data = 16'hAAAA; d_vtag = 8'hFF;
    i_blk = 64'hFFFF_EEEE_DDDD_CCCC; d_blk = 64'h1111_2222_3333_4444;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_freeze", freeze, 0);
    chk("rst_instr", instr, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_strobes", {mem_re, mem_we, d_we, i_we, d_re}, 0);
    chk("rst_d_caddr", d_caddr, 14'(16'h1234 >> 2));
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_wdirty", wdirty, 0);
    i_rd = 0; d_rd = 0;
    @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk);
    #1;

    // dual hit, word 2 of the I block
    run_txn(1, 1, 16'h0006, 1, 0, 1, 0, 16'h0043, 8'h0, 16'h0,
            64'h1111_BEEF_2222_3333, 64'h5555_6666_7777_8888, f);
    // I miss with D hit, fixed 5-cycle memory latency
    force_lat = 5;
    run_txn(1, 0, 16'h0ABD, 1, 0, 1, 0, 16'h0202, 8'h0, 16'h0,
            64'h0, 64'h9999_AAAA_BBBB_CCCC, f);
    chk("i_miss_freeze7", f, 7);
    force_lat = 0;
    // dirty store miss
    run_txn(0, 1, 16'h0000, 0, 1, 0, 1, 16'h0105, 8'h3C, 16'h1234,
            64'h0, 64'hDEAD_BEEF_CAFE_F00D, f);
    // I miss together with dirty D miss
    run_txn(1, 0, 16'h3FF2, 1, 0, 0, 1, 16'h7777, 8'hA5, 16'h0,
            64'h0, 64'h0102_0304_0506_0708, f);
    // store hit alongside I miss
    run_txn(1, 0, 16'h0011, 0, 1, 1, 0, 16'h0422, 8'h0, 16'hFACE,
            64'h0, 64'h1234_5678_9ABC_DEF0, f);

    // reset during DF_WAIT, then a late mem_rdy
    mon_off = 1;
    force_lat = 3;
    d_rd = 1; d_hit = 0; d_dirty = 0; i_rd = 0; d_addr = 16'h2468;
    begin
      bit seen;
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk);
        if (mem_re) seen = 1;
      end
      chk("abort_df_strobe", seen, 1);
    end
    @(posedge clk);
    #1;
    chk("abort_pre_freeze", freeze, 1);
    rst_n = 0;
    d_rd = 0;
    #1;
    chk("abort_freeze", freeze, 0);
    chk("abort_strobes", {mem_re, mem_we, d_we, i_we}, 0);
    @(posedge clk);
    #1 rst_n = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("abort_no_dwe", d_we, 0);
      chk("abort_idle", {freeze, mem_re, mem_we, i_we}, 0);
    end
    @(posedge clk);
    #1;
    force_lat = 0;
    mon_off = 0;
    pc_i = 0; pc_d = 0; pc_w = 0;

    for (int n = 0; n < 200; n++) begin
      int dop;
      dop = int'($urandom_range(0, 2));
      a16 = 16'($urandom);
      run_txn(1'($urandom), 1'($urandom), 16'($urandom), dop == 1, dop == 2,
              1'($urandom), 1'($urandom), a16, 8'($urandom), 16'($urandom),
              {$urandom, $urandom}, {$urandom, $urandom}, f);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

`ifdef PERF_CNT_EN
    chk("i_miss_cnt", i_miss_cnt, pc_i);
    chk("d_miss_cnt", d_miss_cnt, pc_d);
    chk("wb_cnt", wb_cnt, pc_w);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
